// File: rtl/dac_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_conv_pkg
// Description : Shared types and helpers for the DAC stream converter.
//               - state_e     : serializer states (IDLE, EMIT)
//               - EXT_BITS    : guard bits added for the conversion arithmetic
//               - ext_width() : arithmetic width for a given code width (W+2)
//               - midscale()  : offset-binary midscale code 2^(W-1)
// Revision    : 1.0 - initial release
// ============================================================================
package dac_conv_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // Two guard bits: one absorbs the sum of sample, offset and midscale,
   // the other carries the sign so underflow is visible.
   localparam int EXT_BITS = 2;

   function automatic int ext_width(input int w);
      return w + EXT_BITS;
   endfunction

   function automatic longint unsigned midscale(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage : dac_conv_pkg
`default_nettype wire

// File: rtl/dac_code_conv.sv
`default_nettype none
// ============================================================================
// Module      : dac_code_conv
// Description : Combinational single-channel signed-sample to offset-binary
//               DAC code converter: optional negate, signed offset, midscale
//               shift, then clamp (DAC_CONV_SAT_EN defined) or wrap modulo
//               2^W (DAC_CONV_SAT_EN undefined, legacy behaviour).
// Ports       : sample_i  [W-1:0] signed sample
//               invert_i          negate sample before offsetting
//               offset_i  [W-1:0] signed offset
//               code_o    [W-1:0] unsigned DAC code
//               clip_o            result left the code range (always 0 when
//                                 DAC_CONV_SAT_EN is undefined)
// Revision    : 1.0 - initial release
// ============================================================================
module dac_code_conv
   import dac_conv_pkg::*;
#(
   parameter int W = 12
) (
   input  logic [W-1:0] sample_i,
   input  logic         invert_i,
   input  logic [W-1:0] offset_i,
   output logic [W-1:0] code_o,
   output logic         clip_o
);

   localparam int                    EW    = ext_width(W);
   localparam logic signed [EW-1:0]  C_MID = EW'(midscale(W));

   logic signed [EW-1:0] w_x;
   logic signed [EW-1:0] w_off;
   logic signed [EW-1:0] w_v;
   logic signed [EW-1:0] w_r;

   // Sign-extend into the wider arithmetic width; -(-2^(W-1)) and the full
   // three-term sum both fit, so no intermediate overflow is possible.
   assign w_x   = {{(EW-W){sample_i[W-1]}}, sample_i};
   assign w_off = {{(EW-W){offset_i[W-1]}}, offset_i};
   assign w_v   = invert_i ? -w_x : w_x;
   assign w_r   = w_v + w_off + C_MID;

`ifdef DAC_CONV_SAT_EN
   logic w_under;
   logic w_over;

   // |r| < 2^(W+1): the top bit is the sign, bit W flags r >= 2^W.
   assign w_under = w_r[EW-1];
   assign w_over  = ~w_r[EW-1] & w_r[W];

   always_comb begin
      code_o = w_r[W-1:0];
      if (w_under) begin
         code_o = '0;
      end else if (w_over) begin
         code_o = '1;
      end
   end

   assign clip_o = w_under | w_over;
`else
   logic w_unused_hi;

   assign code_o      = w_r[W-1:0];
   assign clip_o      = 1'b0;
   assign w_unused_hi = ^w_r[EW-1:W];
`endif

endmodule : dac_code_conv
`default_nettype wire

// File: rtl/dac_stream_conv.sv
`default_nettype none
// ============================================================================
// Module      : dac_stream_conv
// Description : Multi-channel signed-to-DAC-code converter and serializer.
//               Captures one beat of CH samples, converts every channel in
//               parallel and emits the codes channel 0..CH-1 over a
//               valid/ready stream. A new beat may be accepted on the cycle
//               the last channel is taken, giving bubble-free throughput.
//               Build option DAC_CONV_SAT_EN: clamp out-of-range results and
//               raise the sticky clip flag; otherwise results wrap and clip
//               is tied low.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid/in_ready     input beat handshake
//               in_samples [CH*W]     signed samples, ch k at [k*W +: W]
//               cfg_invert [CH]       per-channel negate
//               cfg_offset [CH*W]     signed per-channel offset
//               out_valid/out_ready   code handshake
//               out_code [W]          unsigned DAC code
//               out_chan [CW]         channel index of out_code
//               out_last              out_code is channel CH-1
//               clip / clip_clr       sticky range flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module dac_stream_conv
   import dac_conv_pkg::*;
#(
   parameter  int W  = 12,
   parameter  int CH = 2,
   localparam int CW = $clog2(CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*W-1:0] in_samples,
   input  logic [CH-1:0]   cfg_invert,
   input  logic [CH*W-1:0] cfg_offset,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_code,
   output logic [CW-1:0]   out_chan,
   output logic            out_last,
   output logic            clip,
   input  logic            clip_clr
);

   localparam logic [W-1:0]  C_MID      = W'(midscale(W));
   localparam logic [CW-1:0] C_LAST_CH  = CW'(CH - 1);

   state_e        state_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [W-1:0]  out_code_q;
   logic [CW-1:0] out_chan_q;
   logic [CW-1:0] out_chan_d;
   logic [W-1:0]  codes_q [CH];

   logic [W-1:0]  w_codes [CH];
   logic [CH-1:0] w_clip;
   logic          w_out_acc;
   logic          w_in_ready;
   logic          w_in_acc;

   generate
      for (genvar k = 0; k < CH; k++) begin : g_chan
         dac_code_conv #(
            .W (W)
         ) u_conv (
            .sample_i (in_samples[k*W +: W]),
            .invert_i (cfg_invert[k]),
            .offset_i (cfg_offset[k*W +: W]),
            .code_o   (w_codes[k]),
            .clip_o   (w_clip[k])
         );
      end
   endgenerate

   assign w_out_acc  = out_valid_q && out_ready;
   // Ready while idle, or on the very cycle the last channel is taken so the
   // next beat follows without a bubble (combinational from out_ready).
   assign w_in_ready = (state_q == ST_IDLE) || (w_out_acc && out_last_q);
   assign w_in_acc   = in_valid && w_in_ready;
   assign out_chan_d = out_chan_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_code_q  <= C_MID;
         out_chan_q  <= '0;
         for (int i = 0; i < CH; i++) begin
            codes_q[i] <= C_MID;
         end
      end else if (w_in_acc) begin
         // Covers both a capture from IDLE and the back-to-back capture on
         // the last-channel accept.
         codes_q     <= w_codes;
         state_q     <= ST_EMIT;
         out_valid_q <= 1'b1;
         out_code_q  <= w_codes[0];
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (w_out_acc) begin
         if (out_last_q) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
         end else begin
            out_chan_q  <= out_chan_d;
            out_code_q  <= codes_q[out_chan_d];
            out_last_q  <= (out_chan_d == C_LAST_CH);
         end
      end
   end

`ifdef DAC_CONV_SAT_EN
   logic clip_q;

   // A capture that clips takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_q <= 1'b0;
      end else if (w_in_acc && (|w_clip)) begin
         clip_q <= 1'b1;
      end else if (clip_clr) begin
         clip_q <= 1'b0;
      end
   end

   assign clip = clip_q;
`else
   logic w_unused_clip;

   assign w_unused_clip = ^{clip_clr, w_clip};
   assign clip          = 1'b0;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_chan  = out_chan_q;
   assign out_last  = out_last_q;

endmodule : dac_stream_conv
`default_nettype wire
